// File: rtl/sfx_pkg.sv
// Shared constants, voice state encoding and the saturating sweep step for sfx_sweep_engine.
package sfx_pkg;

  localparam int MIN_PERIOD   = 2;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PER_W    = 24;
  localparam int DEF_STEP_W   = 16;
  localparam int DEF_LEN_W    = 8;
  localparam int DEF_VOL_W    = 4;

  typedef enum logic {VOICE_IDLE, VOICE_PLAY} voice_state_e;

  // One extra bit of headroom so neither direction can wrap before clamping.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] step,
                                           input logic        dir,
                                           input int unsigned per_w = DEF_PER_W);
    logic [32:0] wide;
    logic [32:0] lim;
    lim = (33'd1 << per_w) - 33'd1;
    if (dir) begin
      wide = {1'b0, cur} - {1'b0, step};
      if (wide[32] || (wide < 33'(MIN_PERIOD))) wide = 33'(MIN_PERIOD);
    end else begin
      wide = {1'b0, cur} + {1'b0, step};
      if (wide > lim) wide = lim;
    end
    return wide[31:0];
  endfunction

endpackage

// File: rtl/sfx_voice.sv
// One sweep-tone voice: trig edge detect, IDLE/PLAY FSM, half-period counter and square wave.
module sfx_voice
  import sfx_pkg::*;
#(
  parameter int PER_W  = DEF_PER_W,
  parameter int STEP_W = DEF_STEP_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              cfg_dir,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              wave
);

  voice_state_e      state;
  logic              trig_q;
  logic              armed;
  logic [PER_W-1:0]  cur;
  logic [PER_W-1:0]  cnt;
  logic [LEN_W-1:0]  rem;
  logic [STEP_W-1:0] step;
  logic              dir;
  logic              start;
  logic [31:0]       nxt_cur;

  // armed only sets after trig is seen low, so a trig held through reset needs a fresh edge
  assign start   = trig & ~trig_q & armed & (cfg_len != '0);
  assign nxt_cur = sat_step(32'(cur), 32'(step), dir, PER_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= VOICE_IDLE;
      trig_q <= 1'b0;
      armed  <= 1'b0;
      busy   <= 1'b0;
      wave   <= 1'b0;
      cur    <= '0;
      cnt    <= '0;
      rem    <= '0;
      step   <= '0;
      dir    <= 1'b0;
    end else begin
      trig_q <= trig;
      if (!trig) armed <= 1'b1;
      if (start) begin
        state <= VOICE_PLAY;
        busy  <= 1'b1;
        wave  <= 1'b0;
        cur   <= (cfg_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cfg_period;
        cnt   <= '0;
        rem   <= cfg_len;
        step  <= cfg_step;
        dir   <= cfg_dir;
      end else begin
        case (state)
          VOICE_IDLE: ;
          VOICE_PLAY: begin
            if (cnt == cur - PER_W'(1)) begin
              cnt <= '0;
              cur <= nxt_cur[PER_W-1:0];
              if (rem == LEN_W'(1)) begin
                state <= VOICE_IDLE;
                busy  <= 1'b0;
                wave  <= 1'b0;
                rem   <= '0;
              end else begin
                wave <= ~wave;
                rem  <= rem - LEN_W'(1);
              end
            end else begin
              cnt <= cnt + PER_W'(1);
            end
          end
          default: state <= VOICE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sfx_sweep_engine.sv
// Multi-voice sweep-tone generator: NUM_CH voices, mixer and first-order delta-sigma output.
// Define SFX_PRIORITY_EN for exclusive mode (only the highest busy voice is heard).
module sfx_sweep_engine
  import sfx_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PER_W  = DEF_PER_W,
  parameter int STEP_W = DEF_STEP_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int VOL_W  = DEF_VOL_W
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic [NUM_CH-1:0]        trig,
  input  logic [NUM_CH*PER_W-1:0]  cfg_period,
  input  logic [NUM_CH*STEP_W-1:0] cfg_step,
  input  logic [NUM_CH-1:0]        cfg_dir,
  input  logic [NUM_CH*LEN_W-1:0]  cfg_len,
  input  logic [VOL_W-1:0]         volume,
  output logic [NUM_CH-1:0]        busy,
  output logic                     audio_out
);

  localparam int VOL_MAX = (1 << VOL_W) - 1;
  localparam int MIX_MAX = NUM_CH * VOL_MAX;
  localparam int ACC_W   = $clog2(2 * MIX_MAX + 1);

  logic [NUM_CH-1:0] wave;
  logic [ACC_W-1:0]  level;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
    sfx_voice #(
      .PER_W (PER_W),
      .STEP_W(STEP_W),
      .LEN_W (LEN_W)
    ) u_voice (
      .clk       (CLK100MHZ),
      .rst_n     (CPU_RESETN),
      .trig      (trig[g]),
      .cfg_period(cfg_period[g*PER_W +: PER_W]),
      .cfg_step  (cfg_step[g*STEP_W +: STEP_W]),
      .cfg_dir   (cfg_dir[g]),
      .cfg_len   (cfg_len[g*LEN_W +: LEN_W]),
      .busy      (busy[g]),
      .wave      (wave[g])
    );
  end

`ifdef SFX_PRIORITY_EN
  localparam int FULL = VOL_MAX;
  logic top_wave;

  always_comb begin
    top_wave = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (busy[i]) top_wave = wave[i];
    end
    level = top_wave ? ACC_W'(volume) : '0;
  end
`else
  localparam int FULL = MIX_MAX;
  logic [ACC_W-1:0] active;

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active = active + ACC_W'(wave[i] & busy[i]);
    end
    level = active * ACC_W'(volume);
  end
`endif

  // acc < FULL and level <= FULL, so ACC_W holds the sum without overflow
  assign sum = acc + level;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      acc       <= '0;
      audio_out <= 1'b0;
    end else if (sum >= ACC_W'(FULL)) begin
      acc       <= sum - ACC_W'(FULL);
      audio_out <= 1'b1;
    end else begin
      acc       <= sum;
      audio_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfx_sweep_engine.sv
// Scoreboard bench for sfx_sweep_engine: expected half-periods queued at trigger, checked per toggle.
module tb_sfx_sweep_engine;

  localparam int NCH = 2;
  localparam int PW  = 8;
  localparam int SW  = 8;
  localparam int LW  = 8;
  localparam int VW  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      trig;
  logic [NCH*PW-1:0]   cfg_period;
  logic [NCH*SW-1:0]   cfg_step;
  logic [NCH-1:0]      cfg_dir;
  logic [NCH*LW-1:0]   cfg_len;
  logic [VW-1:0]       volume;
  logic [NCH-1:0]      busy;
  logic                audio_out;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int sb [NCH][$];
  int last_evt [NCH];
  logic [NCH-1:0] wave_q, busy_q;
  bit mon_en = 1'b0;

  sfx_sweep_engine #(
    .NUM_CH(NCH), .PER_W(PW), .STEP_W(SW), .LEN_W(LW), .VOL_W(VW)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .trig      (trig),
    .cfg_period(cfg_period),
    .cfg_step  (cfg_step),
    .cfg_dir   (cfg_dir),
    .cfg_len   (cfg_len),
    .volume    (volume),
    .busy      (busy),
    .audio_out (audio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Each toggle (or the final busy fall) pops one expected half-period.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (busy_q[i] && ((dut.wave[i] !== wave_q[i]) || !busy[i])) begin
          chk($sformatf("sb%0d_has_entry", i), 32'(sb[i].size() != 0), 1);
          if (sb[i].size() != 0)
            chk($sformatf("half_period_v%0d", i), cyc - last_evt[i], sb[i].pop_front());
          last_evt[i] = cyc;
        end
        wave_q[i] = dut.wave[i];
        busy_q[i] = busy[i];
      end
    end
  end

  task automatic resync();
    for (int i = 0; i < NCH; i++) begin
      wave_q[i] = dut.wave[i];
      busy_q[i] = busy[i];
    end
  endtask

  task automatic fire(input logic [NCH-1:0] mask, input int per, input int stp,
                      input bit d, input int len);
    int cur;
    @(negedge clk);
    trig = trig & ~mask;
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        cfg_period[ch*PW +: PW] = PW'(per);
        cfg_step[ch*SW +: SW]   = SW'(stp);
        cfg_dir[ch]             = d;
        cfg_len[ch*LW +: LW]    = LW'(len);
        trig[ch]                = 1'b1;
        if (len != 0) begin
          sb[ch].delete();
          cur = (per < 2) ? 2 : per;
          for (int k = 0; k < len; k++) begin
            sb[ch].push_back(cur);
            if (d) cur = (cur - stp < 2) ? 2 : cur - stp;
            else   cur = (cur + stp > 255) ? 255 : cur + stp;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (len != 0) begin
      for (int ch = 0; ch < NCH; ch++) if (mask[ch]) last_evt[ch] = cyc;
      resync();
    end
  endtask

  task automatic wait_idle(input int ch);
    int n;
    n = 0;
    while (busy[ch] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_v%0d", ch), 32'(busy[ch]), 0);
    @(negedge clk);
    chk($sformatf("sb%0d_drained", ch), sb[ch].size(), 0);
  endtask

  // Align to the first wave high of voice 0, skip the output latency, count ones.
  task automatic audio_ones(input int n, output int ones);
    int w;
    w = 0;
    while (!dut.wave[0] && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("wave_seen", 32'(dut.wave[0]), 1);
    repeat (2) @(negedge clk);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      ones += int'(audio_out);
    end
  endtask

  initial begin
    int ones;
    int exp_single;
`ifdef SFX_PRIORITY_EN
    exp_single = 6;
`else
    exp_single = 3;
`endif
    rst_n = 1'b0; trig = '0; cfg_period = '0; cfg_step = '0; cfg_dir = '0;
    cfg_len = '0; volume = 4'd15;
    for (int i = 0; i < NCH; i++) last_evt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_audio", 32'(audio_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    resync();
    mon_en = 1'b1;

    // single voice, density while wave high, len-0 edge ignored mid-play
    fire(2'b01, 10, 0, 1'b1, 4);
    audio_ones(6, ones);
    chk("single_voice_density", ones, exp_single);
    fire(2'b01, 3, 0, 1'b0, 0);
    wait_idle(0);

    fire(2'b01, 20, 3, 1'b1, 5);
    wait_idle(0);
    fire(2'b01, 5, 4, 1'b1, 4);
    wait_idle(0);
    fire(2'b01, 250, 10, 1'b0, 3);
    wait_idle(0);

    // retrigger mid-play restarts counters and remaining length
    fire(2'b01, 10, 0, 1'b1, 4);
    repeat (22) @(posedge clk);
    fire(2'b01, 10, 0, 1'b1, 4);
    wait_idle(0);

    fire(2'b11, 20, 0, 1'b1, 4);
    audio_ones(6, ones);
    chk("both_voices_full", ones, 6);
    wait_idle(0);
    wait_idle(1);

    volume = 4'd0;
    fire(2'b01, 20, 0, 1'b1, 4);
    audio_ones(6, ones);
    chk("volume_zero_mute", ones, 0);
    wait_idle(0);
    volume = 4'd15;

    // reset mid-play with trig held high
    fire(2'b01, 10, 0, 1'b1, 4);
    repeat (15) @(posedge clk);
    #1;
    mon_en = 1'b0;
    sb[0].delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_audio", 32'(audio_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("held_trig_no_start", 32'(busy), 0);
    chk("held_trig_audio", 32'(audio_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
